logic_unit_arbiter: RTL and testbench



---
 rtl/logic_unit_arbiter_pkg.sv | 15 +
 rtl/logic_unit.sv | 37 +++
 rtl/logic_unit_arbiter.sv | 105 ++++++++++
 tb/tb_logic_unit_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_arbiter_pkg.sv
// Shared types and constants for the two-port bitwise logic unit arbiter.
package logic_unit_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_ANDN = 2'b11;

endpackage

// File: rtl/logic_unit.sv
// Combinational 32-bit bitwise unit: AND / OR / XOR / ANDN (a & ~b).
// Each bit is built from gate primitives; the opcode only selects among them.
module logic_unit
  import logic_unit_arbiter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0] and_w;
  logic [WIDTH-1:0] or_w;
  logic [WIDTH-1:0] xor_w;
  logic [WIDTH-1:0] nb_w;
  logic [WIDTH-1:0] andn_w;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    and u_and  (and_w[i],  operandA[i], operandB[i]);
    or  u_or   (or_w[i],   operandA[i], operandB[i]);
    xor u_xor  (xor_w[i],  operandA[i], operandB[i]);
    not u_not  (nb_w[i],   operandB[i]);
    and u_andn (andn_w[i], operandA[i], nb_w[i]);
  end

  always_comb begin
    case (op)
      OP_AND:  result = and_w;
      OP_OR:   result = or_w;
      OP_XOR:  result = xor_w;
      default: result = andn_w;
    endcase
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one logic_unit between two requesters.
// One operation in flight: IDLE -> EXEC -> RESP -> IDLE.
//
// state | meaning
// IDLE  | arbitrate; latch winner's op/operands
// EXEC  | grant asserted; unit evaluates latched operands
// RESP  | done pulse for the served port; result valid
module logic_unit_arbiter
  import logic_unit_arbiter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0,
  input  logic [1:0]       op0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [1:0]       op1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  state_e           state_q, state_d;
  logic             sel_q, sel_d;
  logic             last_q, last_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] unit_res;

  logic_unit #(.WIDTH(WIDTH)) u_unit (
    .operandA (a_q),
    .operandB (b_q),
    .op       (op_q),
    .result   (unit_res)
  );

  // last_q resets to 1 so port 0 wins the first tie
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      sel_q    <= 1'b0;
      last_q   <= 1'b1;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      last_q   <= last_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    last_d   = last_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          sel_d   = (req0 && req1) ? ~last_q : req1;
          last_d  = sel_d;
          op_d    = sel_d ? op1 : op0;
          a_d     = sel_d ? a1 : a0;
          b_d     = sel_d ? b1 : b0;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        result_d = unit_res;
        state_d  = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt0   = (state_q == ST_EXEC) && !sel_q;
    gnt1   = (state_q == ST_EXEC) &&  sel_q;
    done0  = (state_q == ST_RESP) && !sel_q;
    done1  = (state_q == ST_RESP) &&  sel_q;
    busy   = (state_q == ST_EXEC) || (state_q == ST_RESP);
    result = result_q;
  end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Bench for logic_unit_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level schedule model.
module tb_logic_unit_arbiter;
  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset;
  logic         req0, req1;
  logic [1:0]   op0, op1;
  logic [W-1:0] a0, b0, a1, b1;
  logic         gnt0, gnt1, done0, done1, busy;
  logic [W-1:0] result;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // model: one op in flight; times are absolute cycle numbers
  int           free_cyc = 0;
  int           gnt_cyc = -10;
  int           done_cyc = -10;
  int           res_cyc = -10;
  bit           srv_port = 1'b0;
  bit           last_port = 1'b1;
  logic [W-1:0] exp_res = '0;
  logic [W-1:0] pend_res = '0;

  int done_order[$];
  int done_at[$];
  logic [W-1:0] done_res[$];

  logic_unit_arbiter #(.WIDTH(W)) dut (
    .clock (clock), .reset (reset),
    .req0 (req0), .op0 (op0), .a0 (a0), .b0 (b0),
    .req1 (req1), .op1 (op1), .a1 (a1), .b1 (b1),
    .gnt0 (gnt0), .gnt1 (gnt1), .done0 (done0), .done1 (done1),
    .result (result), .busy (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_op(input logic [1:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return a & ~b;
    endcase
  endfunction

  // decide what the inputs of the current cycle lead to
  task automatic commit();
    bit w;
    if (reset) begin
      gnt_cyc   = -10;
      done_cyc  = -10;
      res_cyc   = cyc + 1;
      pend_res  = '0;
      last_port = 1'b1;
      free_cyc  = cyc + 1;
    end else if (cyc >= free_cyc && (req0 || req1)) begin
      w         = (req0 && req1) ? ~last_port : req1;
      last_port = w;
      srv_port  = w;
      pend_res  = w ? ref_op(op1, a1, b1) : ref_op(op0, a0, b0);
      gnt_cyc   = cyc + 1;
      done_cyc  = cyc + 2;
      res_cyc   = cyc + 2;
      free_cyc  = cyc + 3;
    end
  endtask

  task automatic check_outs();
    bit g, d;
    if (cyc == res_cyc) exp_res = pend_res;
    g = (cyc == gnt_cyc);
    d = (cyc == done_cyc);
    check("ctrl{g1,g0,d1,d0,busy}", {59'd0, gnt1, gnt0, done1, done0, busy},
          {59'd0, g && srv_port, g && !srv_port, d && srv_port, d && !srv_port, g || d});
    check("result", {32'd0, result}, {32'd0, exp_res});
  endtask

  task automatic cycle_end();
    commit();
    @(posedge clock);
    cyc++;
    @(negedge clock);
    check_outs();
  endtask

  task automatic clear_log();
    done_order.delete();
    done_at.delete();
    done_res.delete();
  endtask

  task automatic run_ops(input int n, input bit keep0, input bit keep1, input bit scramble);
    int got = 0;
    int budget = 0;
    while (got < n && budget < 200) begin
      cycle_end();
      budget++;
      if (scramble && cyc == gnt_cyc) begin
        if (srv_port) a1 = '0; else a0 = '0;
      end
      if (cyc == done_cyc) begin
        got++;
        done_order.push_back(int'(srv_port));
        done_at.push_back(cyc);
        done_res.push_back(result);
        if (srv_port) begin
          if (!keep1) req1 = 1'b0;
        end else if (!keep0) req0 = 1'b0;
      end
    end
    if (got < n) check("timeout_ops", 64'(got), 64'(n));
  endtask

  task automatic go_idle(input int n);
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (n) cycle_end();
  endtask

  initial begin
    reset = 1'b1;
    req0 = 1'b0; op0 = '0; a0 = '0; b0 = '0;
    req1 = 1'b0; op1 = '0; a1 = '0; b1 = '0;
    cycle_end();
    cycle_end();
    reset = 1'b0;
    repeat (5) cycle_end();
    check("idle_busy", {63'd0, busy}, 64'd0);

    // single requester on port 0
    clear_log();
    req0 = 1'b1; op0 = 2'b00; a0 = 32'hFFFF0000; b0 = 32'h0F0F0F0F;
    run_ops(1, 1'b0, 1'b0, 1'b0);
    if (done_res.size() == 1) check("t1_res", {32'd0, done_res[0]}, {32'd0, 32'h0F0F0000});
    go_idle(2);

    // contention straight out of reset: port 0 first
    clear_log();
    reset = 1'b1;
    req0 = 1'b1; op0 = 2'b01; a0 = 32'h000000F0; b0 = 32'h0000000F;
    req1 = 1'b1; op1 = 2'b10; a1 = 32'hFFFFFFFF; b1 = 32'h12345678;
    cycle_end();
    reset = 1'b0;
    run_ops(2, 1'b0, 1'b0, 1'b0);
    if (done_order.size() == 2) begin
      check("t3_order", 64'({done_order[0][0], done_order[1][0]}), 64'b01);
      check("t3_res0", {32'd0, done_res[0]}, {32'd0, 32'h000000FF});
      check("t3_res1", {32'd0, done_res[1]}, {32'd0, 32'hEDCBA987});
      check("t3_gap", 64'(done_at[1] - done_at[0]), 64'd3);
    end
    go_idle(2);

    // continuous contention for four operations
    clear_log();
    req0 = 1'b1; req1 = 1'b1;
    run_ops(4, 1'b1, 1'b1, 1'b0);
    if (done_order.size() == 4)
      check("t4_order", 64'({done_order[0][0], done_order[1][0], done_order[2][0],
                             done_order[3][0]}), 64'b0101);
    go_idle(2);

    // operands altered during EXEC must not matter
    clear_log();
    req1 = 1'b1; op1 = 2'b11; a1 = 32'hFFFFFFFF; b1 = 32'h0000FFFF;
    run_ops(1, 1'b0, 1'b0, 1'b1);
    if (done_res.size() == 1) check("t5_res", {32'd0, done_res[0]}, {32'd0, 32'hFFFF0000});
    go_idle(2);

    // reset during EXEC of a port-1 op, then restart
    clear_log();
    req1 = 1'b1; op1 = 2'b10; a1 = 32'h0000FFFF; b1 = 32'h00FF00FF;
    cycle_end();
    check("t6_gnt1", {63'd0, gnt1}, 64'd1);
    reset = 1'b1;
    cycle_end();
    check("t6_done1", {63'd0, done1}, 64'd0);
    check("t6_res", {32'd0, result}, 64'd0);
    reset = 1'b0;
    begin
      int rel;
      rel = cyc;
      run_ops(1, 1'b0, 1'b0, 1'b0);
      if (done_at.size() == 1) begin
        check("t6_lat", 64'(done_at[0] - rel), 64'd2);
        check("t6_res2", {32'd0, done_res[0]}, {32'd0, 32'h00FFFF00});
      end
    end
    go_idle(2);

    // randomized traffic with occasional resets and EXEC-time operand changes
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(99) == 0);
      if (!req0 && $urandom_range(2) == 0) begin
        req0 = 1'b1; op0 = 2'($urandom_range(3)); a0 = $urandom; b0 = $urandom;
      end
      if (!req1 && $urandom_range(2) == 0) begin
        req1 = 1'b1; op1 = 2'($urandom_range(3)); a1 = $urandom; b1 = $urandom;
      end
      cycle_end();
      if (cyc == gnt_cyc && $urandom_range(1) == 0) begin
        if (srv_port) a1 = $urandom; else a0 = $urandom;
      end
      if (cyc == done_cyc) begin
        if (srv_port) req1 = 1'b0; else req0 = 1'b0;
      end
    end
    reset = 1'b0;
    go_idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
